// File: rtl/bp_initiator_if.sv
// Request, response and BytePipe signals of the BytePipe initiator.
// master: the initiator; slave: the surrounding system/responder.
interface bp_initiator_if;
    logic       i_req_valid;
    logic       o_req_ready;
    logic [1:0] i_req_op;
    logic [6:0] i_req_addr;
    logic [7:0] i_req_wdata;
    logic [7:0] i_req_len;

    logic [7:0] o_rsp_data;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic       o_rsp_last;
    logic       o_rsp_err;

    logic [7:0] o_bp_data;
    logic       o_bp_valid;
    logic       i_bp_ready;
    logic [7:0] i_bp_data;
    logic       i_bp_valid;
    logic       o_bp_ready;
    logic       o_busy;

    modport master (
        input  i_req_valid, i_req_op, i_req_addr, i_req_wdata, i_req_len,
        input  i_rsp_ready, i_bp_ready, i_bp_data, i_bp_valid,
        output o_req_ready, o_rsp_data, o_rsp_valid, o_rsp_last,
        output o_rsp_err, o_bp_data, o_bp_valid, o_bp_ready, o_busy
    );

    modport slave (
        output i_req_valid, i_req_op, i_req_addr, i_req_wdata, i_req_len,
        output i_rsp_ready, i_bp_ready, i_bp_data, i_bp_valid,
        input  o_req_ready, o_rsp_data, o_rsp_valid, o_rsp_last,
        input  o_rsp_err, o_bp_data, o_bp_valid, o_bp_ready, o_busy
    );
endinterface

// File: rtl/bp_initiator.sv
// BytePipe initiator: turns register read/write/burst requests into
// command bytes and streams the responder's replies back out.
module bp_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic         i_clk,
    input logic         i_rst_n,
    bp_initiator_if.master bp
);

    localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, SETUP_CMD, SETUP_DATA, SETUP_ACK, CMD, WDATA, RESP
    } state_e;

    state_e      state_q, state_d;
    logic        bp_valid_q, bp_valid_d;
    logic [7:0]  bp_data_q, bp_data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] wait_q, wait_d;
    logic        wr_q, wr_d;
    logic        burst_q, burst_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  n_q, n_d;
    logic        rdy_q;

    logic        req_ready;
    logic        bp_fire;
    logic        timeout;
    logic [7:0]  rsp_data;
    logic        rsp_valid, rsp_last, rsp_err, bp_ready;

    assign req_ready = rdy_q && (state_q == IDLE);
    assign bp_fire   = bp_valid_q && bp.i_bp_ready;
    assign timeout   = (wait_q == TO);

    // rdy_q keeps o_req_ready low until the first edge after reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            bp_valid_q <= 1'b0;
            bp_data_q  <= 8'h00;
            cnt_q      <= 8'h00;
            wait_q     <= 16'h0000;
            wr_q       <= 1'b0;
            burst_q    <= 1'b0;
            addr_q     <= 7'h00;
            wdata_q    <= 8'h00;
            n_q        <= 8'h00;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bp_valid_q <= bp_valid_d;
            bp_data_q  <= bp_data_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            wr_q       <= wr_d;
            burst_q    <= burst_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            n_q        <= n_d;
            rdy_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        wr_d    = wr_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        n_d     = n_q;

        unique case (state_q)
            IDLE: begin
                if (bp.i_req_valid && req_ready) begin
                    wr_d    = (bp.i_req_op == 2'd1);
                    burst_d = (bp.i_req_op == 2'd2);
                    addr_d  = bp.i_req_addr;
                    wdata_d = bp.i_req_wdata;
                    n_d     = (bp.i_req_len == 8'd0) ? 8'd1 : bp.i_req_len;
                    state_d = (bp.i_req_op == 2'd2) ? SETUP_CMD : CMD;
                end
            end
            SETUP_CMD: begin
                if (bp_fire) state_d = SETUP_DATA;
            end
            SETUP_DATA: begin
                if (bp_fire) begin
                    state_d = SETUP_ACK;
                    wait_d  = 16'h0000;
                end
            end
            SETUP_ACK: begin
                if (bp.i_bp_valid) begin
                    state_d = CMD;
                    wait_d  = 16'h0000;
                end else if (timeout) begin
                    if (bp.i_rsp_ready) state_d = IDLE;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            CMD: begin
                if (bp_fire) begin
                    if (wr_q) begin
                        state_d = WDATA;
                    end else begin
                        state_d = RESP;
                        cnt_d   = burst_q ? n_q : 8'd1;
                        wait_d  = 16'h0000;
                    end
                end
            end
            WDATA: begin
                if (bp_fire) begin
                    state_d = RESP;
                    cnt_d   = 8'd1;
                    wait_d  = 16'h0000;
                end
            end
            RESP: begin
                if (bp.i_bp_valid) begin
                    if (bp.i_rsp_ready) begin
                        cnt_d  = cnt_q - 8'd1;
                        wait_d = 16'h0000;
                        if (cnt_q == 8'd1) state_d = IDLE;
                    end
                end else if (bp.i_rsp_ready) begin
                    if (timeout) state_d = IDLE;
                    else         wait_d  = wait_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            cnt_d  = 8'h00;
            wait_d = 16'h0000;
        end

        // outgoing byte is registered from the state being entered
        bp_valid_d = (state_d == SETUP_CMD) || (state_d == SETUP_DATA) ||
                     (state_d == CMD) || (state_d == WDATA);
        unique case (state_d)
            SETUP_CMD:  bp_data_d = 8'h80;
            SETUP_DATA: bp_data_d = n_d - 8'd1;
            CMD:        bp_data_d = {wr_d, addr_d};
            WDATA:      bp_data_d = wdata_d;
            default:    bp_data_d = 8'h00;
        endcase
    end

    always_comb begin
        rsp_valid = 1'b0;
        rsp_data  = 8'h00;
        rsp_last  = 1'b0;
        rsp_err   = 1'b0;
        bp_ready  = 1'b0;
        unique case (1'b1)
            (state_q == SETUP_ACK): begin
                bp_ready = 1'b1;
                if (!bp.i_bp_valid && timeout) begin
                    rsp_valid = 1'b1;
                    rsp_last  = 1'b1;
                    rsp_err   = 1'b1;
                end
            end
            (state_q == RESP): begin
                bp_ready = bp.i_rsp_ready;
                if (bp.i_bp_valid) begin
                    rsp_valid = 1'b1;
                    rsp_data  = bp.i_bp_data;
                    rsp_last  = (cnt_q == 8'd1);
                end else if (timeout) begin
                    rsp_valid = 1'b1;
                    rsp_last  = 1'b1;
                    rsp_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bp.o_req_ready = req_ready;
    assign bp.o_rsp_data  = rsp_data;
    assign bp.o_rsp_valid = rsp_valid;
    assign bp.o_rsp_last  = rsp_last;
    assign bp.o_rsp_err   = rsp_err;
    assign bp.o_bp_data   = bp_data_q;
    assign bp.o_bp_valid  = bp_valid_q;
    assign bp.o_bp_ready  = bp_ready;
    assign bp.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bp_initiator.sv
// Directed bench for bp_initiator: read, write, burst, backpressure,
// timeout, len=0 and reset in the middle of a burst.
module tb_bp_initiator;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bp_initiator_if bus ();

    bp_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bp      (bus)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [1:0] op, input logic [6:0] a,
                            input logic [7:0] wd, input logic [7:0] ln);
        int k = 0;
        while (!bus.o_req_ready && k < 20) begin
            tick();
            k++;
        end
        chk("req_ready", 8'(bus.o_req_ready), 8'd1);
        bus.i_req_valid = 1'b1;
        bus.i_req_op    = op;
        bus.i_req_addr  = a;
        bus.i_req_wdata = wd;
        bus.i_req_len   = ln;
        tick();
        bus.i_req_valid = 1'b0;
    endtask

    task automatic xfer_out(input string tag, input logic [7:0] exp);
        int k = 0;
        while (!bus.o_bp_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_valid"}, 8'(bus.o_bp_valid), 8'd1);
        chk(tag, bus.o_bp_data, exp);
        chk({tag, "_bprdy"}, 8'(bus.o_bp_ready), 8'd0);
        bus.i_bp_ready = 1'b1;
        tick();
        bus.i_bp_ready = 1'b0;
    endtask

    task automatic rsp_in(input string tag, input logic [7:0] d,
                          input logic last);
        bus.i_bp_valid  = 1'b1;
        bus.i_bp_data   = d;
        bus.i_rsp_ready = 1'b1;
        #1;
        chk({tag, "_valid"}, 8'(bus.o_rsp_valid), 8'd1);
        chk({tag, "_data"}, bus.o_rsp_data, d);
        chk({tag, "_last"}, 8'(bus.o_rsp_last), 8'(last));
        chk({tag, "_err"}, 8'(bus.o_rsp_err), 8'd0);
        chk({tag, "_bprdy"}, 8'(bus.o_bp_ready), 8'd1);
        tick();
        bus.i_bp_valid = 1'b0;
        bus.i_bp_data  = 8'h00;
    endtask

    task automatic setup_ack(input string tag);
        chk({tag, "_bprdy"}, 8'(bus.o_bp_ready), 8'd1);
        bus.i_bp_valid = 1'b1;
        bus.i_bp_data  = 8'h00;
        #1;
        chk({tag, "_fwd"}, 8'(bus.o_rsp_valid), 8'd0);
        tick();
        bus.i_bp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_req_op    = 2'd0;
        bus.i_req_addr  = 7'h00;
        bus.i_req_wdata = 8'h00;
        bus.i_req_len   = 8'h00;
        bus.i_rsp_ready = 1'b0;
        bus.i_bp_ready  = 1'b0;
        bus.i_bp_data   = 8'h00;
        bus.i_bp_valid  = 1'b0;
        rst_n = 1'b0;

        #2;
        chk("rst_busy", 8'(bus.o_busy), 8'd0);
        chk("rst_bpv", 8'(bus.o_bp_valid), 8'd0);
        chk("rst_bpd", bus.o_bp_data, 8'h00);
        chk("rst_rspv", 8'(bus.o_rsp_valid), 8'd0);
        chk("rst_reqrdy", 8'(bus.o_req_ready), 8'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rel_reqrdy", 8'(bus.o_req_ready), 8'd0);
        tick();
        chk("post_reqrdy", 8'(bus.o_req_ready), 8'd1);

        // read
        send_req(2'd0, 7'h07, 8'h00, 8'h00);
        chk("rd_busy", 8'(bus.o_busy), 8'd1);
        xfer_out("rd_cmd", 8'h07);
        rsp_in("rd_rsp", 8'h05, 1'b1);
        chk("rd_idle", 8'(bus.o_busy), 8'd0);
        chk("rd_reqrdy", 8'(bus.o_req_ready), 8'd1);

        // write with readback
        send_req(2'd1, 7'h07, 8'h03, 8'h00);
        xfer_out("wr_cmd", 8'h87);
        xfer_out("wr_data", 8'h03);
        rsp_in("wr_rsp", 8'h03, 1'b1);
        chk("wr_idle", 8'(bus.o_busy), 8'd0);

        // burst of 4
        send_req(2'd2, 7'h01, 8'h00, 8'd4);
        xfer_out("bu_setc", 8'h80);
        xfer_out("bu_setd", 8'h03);
        setup_ack("bu_ack");
        xfer_out("bu_cmd", 8'h01);
        rsp_in("bu_r0", 8'hA0, 1'b0);
        rsp_in("bu_r1", 8'hA1, 1'b0);
        rsp_in("bu_r2", 8'hA2, 1'b0);
        rsp_in("bu_r3", 8'hA3, 1'b1);
        chk("bu_idle", 8'(bus.o_busy), 8'd0);

        // burst with len=0 behaves as len=1
        send_req(2'd2, 7'h05, 8'h00, 8'd0);
        xfer_out("l0_setc", 8'h80);
        xfer_out("l0_setd", 8'h00);
        setup_ack("l0_ack");
        xfer_out("l0_cmd", 8'h05);
        rsp_in("l0_r0", 8'h77, 1'b1);
        chk("l0_idle", 8'(bus.o_busy), 8'd0);

        // backpressure on both sides
        send_req(2'd0, 7'h15, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_v", 8'(bus.o_bp_valid), 8'd1);
            chk("bp_hold_d", bus.o_bp_data, 8'h15);
            tick();
        end
        xfer_out("bp_cmd", 8'h15);
        bus.i_rsp_ready = 1'b0;
        bus.i_bp_valid  = 1'b1;
        bus.i_bp_data   = 8'h44;
        #1;
        chk("bp_stall_rdy", 8'(bus.o_bp_ready), 8'd0);
        chk("bp_stall_v", 8'(bus.o_rsp_valid), 8'd1);
        chk("bp_stall_d", bus.o_rsp_data, 8'h44);
        tick();
        bus.i_bp_valid = 1'b0;
        repeat (12) tick();
        chk("bp_noto_err", 8'(bus.o_rsp_err), 8'd0);
        chk("bp_noto_v", 8'(bus.o_rsp_valid), 8'd0);
        chk("bp_noto_busy", 8'(bus.o_busy), 8'd1);
        rsp_in("bp_rsp", 8'h44, 1'b1);
        chk("bp_idle", 8'(bus.o_busy), 8'd0);

        // timeout after a silent responder
        send_req(2'd0, 7'h22, 8'h00, 8'h00);
        xfer_out("to_cmd", 8'h22);
        bus.i_rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("to_early", 8'(bus.o_rsp_err), 8'd0);
            tick();
        end
        bus.i_rsp_ready = 1'b0;
        #1;
        chk("to_err", 8'(bus.o_rsp_err), 8'd1);
        chk("to_valid", 8'(bus.o_rsp_valid), 8'd1);
        chk("to_data", bus.o_rsp_data, 8'h00);
        chk("to_last", 8'(bus.o_rsp_last), 8'd1);
        tick();
        chk("to_held", 8'(bus.o_rsp_err), 8'd1);
        chk("to_busy", 8'(bus.o_busy), 8'd1);
        bus.i_rsp_ready = 1'b1;
        tick();
        chk("to_idle", 8'(bus.o_busy), 8'd0);
        chk("to_reqrdy", 8'(bus.o_req_ready), 8'd1);
        chk("to_errclr", 8'(bus.o_rsp_err), 8'd0);

        // byte arriving on the timeout cycle wins
        send_req(2'd0, 7'h23, 8'h00, 8'h00);
        xfer_out("tb_cmd", 8'h23);
        bus.i_rsp_ready = 1'b1;
        repeat (8) tick();
        rsp_in("tb_rsp", 8'h5A, 1'b1);
        chk("tb_idle", 8'(bus.o_busy), 8'd0);

        // reset in the middle of a burst
        send_req(2'd2, 7'h02, 8'h00, 8'd4);
        xfer_out("rs_setc", 8'h80);
        xfer_out("rs_setd", 8'h03);
        setup_ack("rs_ack");
        xfer_out("rs_cmd", 8'h02);
        rsp_in("rs_r0", 8'hB0, 1'b0);
        rsp_in("rs_r1", 8'hB1, 1'b0);
        bus.i_bp_valid  = 1'b1;
        bus.i_bp_data   = 8'hB2;
        bus.i_rsp_ready = 1'b1;
        #1 chk("rs_pre_v", 8'(bus.o_rsp_valid), 8'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rs_busy", 8'(bus.o_busy), 8'd0);
        chk("rs_bpv", 8'(bus.o_bp_valid), 8'd0);
        chk("rs_bpd", bus.o_bp_data, 8'h00);
        chk("rs_rspv", 8'(bus.o_rsp_valid), 8'd0);
        chk("rs_last", 8'(bus.o_rsp_last), 8'd0);
        chk("rs_bprdy", 8'(bus.o_bp_ready), 8'd0);
        chk("rs_reqrdy", 8'(bus.o_req_ready), 8'd0);
        bus.i_bp_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send_req(2'd0, 7'h07, 8'h00, 8'h00);
        xfer_out("rs_rd_cmd", 8'h07);
        rsp_in("rs_rd_rsp", 8'h11, 1'b1);
        chk("rs_rd_idle", 8'(bus.o_busy), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
